// File: rtl/prominence_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : prominence_stream_tx
// Description : Reads peak records (prominence, value, index) out of a
//               field-major buffer and emits them as one AXI-Stream frame of
//               3*count beats, with tuser on the first and tlast on the last.
// Revision    : 1.0 - initial release
// ============================================================================
module prominence_stream_tx #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    count,
    output logic [9:0]    buf_addr,
    output logic          buf_rd,
    input  logic [DW-1:0] buf_rdata,
    output logic [DW-1:0] tdata_m,
    output logic          tuser_m,
    output logic          tlast_m,
    output logic          tvalid_m,
    input  logic          tready_m,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    r_q, r_d;          // record index within the frame
    logic [1:0]    f_q, f_d;          // field index within the record
    logic [7:0]    cnt_q, cnt_d;      // record count latched at start
    logic [DW-1:0] tdata_q, tdata_d;
    logic          tuser_q, tuser_d;
    logic          tlast_q, tlast_d;
    logic          tvalid_q, tvalid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          buf_rd_q, buf_rd_d;
    logic [9:0]    buf_addr_q, buf_addr_d;
    logic [DW-1:0] idx_ext;           // peak index field, zero-extended

    // Next-state and next-output computation; every output is the registered
    // image of the state being entered, so nothing downstream sees a comb path.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        f_d        = f_q;
        cnt_d      = cnt_q;
        tdata_d    = tdata_q;
        tuser_d    = tuser_q;
        tlast_d    = tlast_q;
        tvalid_d   = 1'b0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        buf_rd_d   = 1'b0;
        buf_addr_d = '0;
        idx_ext    = '0;
        idx_ext[9:0] = buf_rdata[9:0];

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if (count != 8'd0) begin
                        cnt_d      = count;
                        r_d        = 8'd0;
                        f_d        = 2'd0;
                        buf_rd_d   = 1'b1;
                        buf_addr_d = 10'd0;
                        state_d    = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                tdata_d  = (f_q == 2'd2) ? idx_ext : buf_rdata;
                tuser_d  = (r_q == 8'd0) && (f_q == 2'd0);
                tlast_d  = (r_q == (cnt_q - 8'd1)) && (f_q == 2'd2);
                tvalid_d = 1'b1;
                state_d  = S_SEND;
            end
            S_SEND: begin
                tvalid_d = 1'b1;
                if (tready_m) begin
                    tvalid_d = 1'b0;
                    if (tlast_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        if (f_q == 2'd2) begin
                            f_d = 2'd0;
                            r_d = r_q + 8'd1;
                        end else begin
                            f_d = f_q + 2'd1;
                        end
                        buf_rd_d   = 1'b1;
                        buf_addr_d = {f_d, r_d};
                        state_d    = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over any handshake; the frame is cut and the sink
        // resynchronises on the next tuser.
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            tvalid_d   = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            buf_rd_d   = 1'b0;
            buf_addr_d = '0;
        end
    end

    // State and output registers; reset wins over ce, ce=0 freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            f_q        <= '0;
            cnt_q      <= '0;
            tdata_q    <= '0;
            tuser_q    <= 1'b0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            buf_rd_q   <= 1'b0;
            buf_addr_q <= '0;
        end else if (ce) begin
            state_q    <= state_d;
            r_q        <= r_d;
            f_q        <= f_d;
            cnt_q      <= cnt_d;
            tdata_q    <= tdata_d;
            tuser_q    <= tuser_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            buf_rd_q   <= buf_rd_d;
            buf_addr_q <= buf_addr_d;
        end
    end

    assign tdata_m  = tdata_q;
    assign tuser_m  = tuser_q;
    assign tlast_m  = tlast_q;
    assign tvalid_m = tvalid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign buf_rd   = buf_rd_q;
    assign buf_addr = buf_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_prominence_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_prominence_stream_tx
// Description : Directed bench for prominence_stream_tx with a beat
//               scoreboard and a one-cycle-latency buffer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prominence_stream_tx;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset, ce, start, abort, tready_m;
    logic [7:0]    count;
    logic [9:0]    buf_addr;
    logic          buf_rd;
    logic [DW-1:0] buf_rdata;
    logic [DW-1:0] tdata_m;
    logic          tuser_m, tlast_m, tvalid_m, busy, done;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] mem [0:1023];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int beats = 0;
    int done_cnt = 0;
    int rd_seen  = 0;
    int done_cyc = 0;
    int last_hs_cyc = 0;
    logic          prev_v = 1'b0, prev_hs = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic          prev_u = 1'b0, prev_l = 1'b0;

    prominence_stream_tx #(.DW(DW)) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start), .abort(abort),
        .count(count), .buf_addr(buf_addr), .buf_rd(buf_rd),
        .buf_rdata(buf_rdata), .tdata_m(tdata_m), .tuser_m(tuser_m),
        .tlast_m(tlast_m), .tvalid_m(tvalid_m), .tready_m(tready_m),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Buffer: read data appears one cycle after the strobe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (buf_rd) buf_rdata <= mem[buf_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pops, hold-stability, done/strobe bookkeeping
    always @(negedge clk) begin
        logic hs;
        beat_t e;
        if (buf_rd) rd_seen++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (tvalid_m && prev_v && !prev_hs) begin
            check("hold_tdata", 32'(tdata_m), 32'(prev_d));
            check("hold_tuser", 32'(tuser_m), 32'(prev_u));
            check("hold_tlast", 32'(tlast_m), 32'(prev_l));
        end
        hs = ce && tvalid_m && tready_m && !reset && !abort;
        if (hs) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 32'(tdata_m), 32'(e.d));
                check("beat_user", 32'(tuser_m), 32'(e.u));
                check("beat_last", 32'(tlast_m), 32'(e.l));
            end
            beats++;
            last_hs_cyc = cyc;
        end
        prev_v  = tvalid_m;
        prev_hs = hs;
        prev_d  = tdata_m;
        prev_u  = tuser_m;
        prev_l  = tlast_m;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected frame derived from the buffer contents
    task automatic push_frame(input int n);
        beat_t b;
        logic [1:0] f2;
        logic [7:0] r8;
        for (int r = 0; r < n; r++) begin
            for (int f = 0; f < 3; f++) begin
                f2 = 2'(f);
                r8 = 8'(r);
                b.d = mem[{f2, r8}];
                if (f == 2) b.d = {6'd0, mem[{f2, r8}][9:0]};
                b.u = (r == 0) && (f == 0);
                b.l = (r == n - 1) && (f == 2);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic u, input logic l);
        beat_t b;
        b.d = d; b.u = u; b.l = l;
        exp_q.push_back(b);
    endtask

    // Pulse start and measure edges until tvalid rises (counting the start edge)
    task automatic start_frame(input logic [7:0] n, input string tag);
        int k;
        count = n;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!tvalid_m && k < 20) begin
            step();
            k++;
        end
        check(tag, 32'(k + 1), 32'd3);
    endtask

    task automatic wait_done(input string tag, input int bound);
        int d0, k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < bound) begin
            step();
            k++;
        end
        check(tag, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!tvalid_m && k < 20) begin
            step();
            k++;
        end
        check(tag, 32'(tvalid_m), 32'd1);
    endtask

    task automatic hs_one();
        wait_valid("hs_wait_valid");
        tready_m = 1'b1;
        step();
        tready_m = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 32'(tvalid_m), 32'd0);
        check({tag, "_tuser"},  32'(tuser_m),  32'd0);
        check({tag, "_tlast"},  32'(tlast_m),  32'd0);
        check({tag, "_tdata"},  32'(tdata_m),  32'd0);
        check({tag, "_done"},   32'(done),     32'd0);
        check({tag, "_busy"},   32'(busy),     32'd0);
        check({tag, "_buf_rd"}, 32'(buf_rd),   32'd0);
        check({tag, "_addr"},   32'(buf_addr), 32'd0);
    endtask

    initial begin
        int b0, d0, r0;
        for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
        buf_rdata = '0;
        reset = 1'b1; ce = 1'b1; start = 1'b0; abort = 1'b0;
        count = 8'd0; tready_m = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        // Known two-record frame
        mem[{2'd0, 8'd0}] = 16'd100;
        mem[{2'd0, 8'd1}] = 16'hFFFB;
        mem[{2'd1, 8'd0}] = 16'd300;
        mem[{2'd1, 8'd1}] = 16'd40;
        mem[{2'd2, 8'd0}] = 16'h03FF;
        mem[{2'd2, 8'd1}] = 16'd7;
        push_beat(16'd100,  1'b1, 1'b0);
        push_beat(16'd300,  1'b0, 1'b0);
        push_beat(16'h03FF, 1'b0, 1'b0);
        push_beat(16'hFFFB, 1'b0, 1'b0);
        push_beat(16'd40,   1'b0, 1'b0);
        push_beat(16'd7,    1'b0, 1'b1);
        b0 = beats;
        tready_m = 1'b1;
        start_frame(8'd2, "latency_c2");
        wait_done("done_c2", 100);
        check("beats_c2", 32'(beats - b0), 32'd6);
        check("queue_c2", 32'(exp_q.size()), 32'd0);
        check("done_after_last", 32'(done_cyc), 32'(last_hs_cyc + 1));
        check("busy_after_c2", 32'(busy), 32'd0);

        // Empty frame
        step();
        r0 = rd_seen; d0 = done_cnt;
        count = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("c0_done", 32'(done), 32'd1);
        check("c0_tvalid", 32'(tvalid_m), 32'd0);
        check("c0_busy", 32'(busy), 32'd1);
        step();
        check("c0_done_end", 32'(done), 32'd0);
        check("c0_busy_end", 32'(busy), 32'd0);
        check("c0_no_rd", 32'(rd_seen), 32'(r0));
        check("c0_done_cnt", 32'(done_cnt), 32'(d0 + 1));

        // Backpressure: 5 stalled cycles in every SEND
        push_frame(1);
        tready_m = 1'b0;
        start_frame(8'd1, "latency_stall");
        for (int b = 0; b < 3; b++) begin
            wait_valid("stall_valid");
            repeat (5) step();
            tready_m = 1'b1;
            step();
            tready_m = 1'b0;
        end
        wait_done("done_stall", 50);
        check("queue_stall", 32'(exp_q.size()), 32'd0);

        // Abort during beat 4, then a clean frame
        push_frame(3);
        tready_m = 1'b0;
        count = 8'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 3; b++) hs_one();
        wait_valid("abort_b4_valid");
        d0 = done_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_tvalid", 32'(tvalid_m), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_left", 32'(exp_q.size()), 32'd6);
        exp_q.delete();
        repeat (4) step();
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        push_frame(1);
        tready_m = 1'b1;
        start_frame(8'd1, "latency_after_abort");
        wait_done("done_after_abort", 50);
        check("queue_after_abort", 32'(exp_q.size()), 32'd0);

        // Start re-pulsed mid-frame is ignored
        push_frame(2);
        b0 = beats;
        start_frame(8'd2, "latency_repulse");
        count = 8'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("done_repulse", 100);
        repeat (10) step();
        check("beats_repulse", 32'(beats - b0), 32'd6);
        check("queue_repulse", 32'(exp_q.size()), 32'd0);

        // Reset during LOAD with ce low
        push_frame(1);
        tready_m = 1'b0;
        count = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        ce = 1'b0;
        reset = 1'b1;
        d0 = done_cnt;
        step();
        check_reset_outputs("reset_load");
        reset = 1'b0;
        ce = 1'b1;
        exp_q.delete();
        step();
        check("reset_no_done", 32'(done_cnt), 32'(d0));

        // ce low for 4 cycles in SEND freezes the beat
        push_frame(1);
        start_frame(8'd1, "latency_ce");
        ce = 1'b0;
        tready_m = 1'b1;
        b0 = beats;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ce_hold_tvalid", 32'(tvalid_m), 32'd1);
            check("ce_hold_busy", 32'(busy), 32'd1);
        end
        check("ce_no_hs", 32'(beats - b0), 32'd0);
        ce = 1'b1;
        wait_done("done_ce", 50);
        check("queue_ce", 32'(exp_q.size()), 32'd0);

        // Maximum record count
        push_frame(255);
        b0 = beats;
        tready_m = 1'b1;
        start_frame(8'd255, "latency_c255");
        wait_done("done_c255", 3000);
        check("beats_c255", 32'(beats - b0), 32'd765);
        check("queue_c255", 32'(exp_q.size()), 32'd0);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prominence_stream_tx.md
PROMINENCE_STREAM_TX -- requirements
Module: prominence_stream_tx

Interface
REQ-001 Parameter DW, default 16, stream data width and buffer word width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ce  input  1  clock enable; when low, all state and outputs hold.
REQ-005 start  input  1  one-cycle request to begin a readout.
REQ-006 abort  input  1  one-cycle request to terminate a readout.
REQ-007 count  input  8  number of peak records to send; sampled at accepted start.
REQ-008 buf_addr  output  10  buffer read address.
REQ-009 buf_rd  output  1  buffer read strobe.
REQ-010 buf_rdata  input  DW  buffer read data, valid exactly 1 cycle after buf_rd.
REQ-011 tdata_m  output  DW  AXI-Stream data.
REQ-012 tuser_m  output  1  first beat of frame.
REQ-013 tlast_m  output  1  last beat of frame.
REQ-014 tvalid_m  output  1  stream valid.
REQ-015 tready_m  input  1  stream ready.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 Buffer layout: field f in {0 prominence, 1 peak value, 2 peak index}; record r at buf_addr = {f[1:0], r[7:0]}.
REQ-019 Frame = count records, r = 0..count-1 ascending, each as 3 beats in order f=0,1,2; 3*count beats in total.
REQ-020 f=0 and f=1 beats pass buf_rdata unchanged (signed); f=2 beats carry buf_rdata[9:0], zero-extended to DW.
REQ-021 FSM states: IDLE, FETCH, LOAD, SEND, DONE.
REQ-022 IDLE: start=1 with count>0 -> FETCH, latching count and clearing r and f; start=1 with count=0 -> DONE; no beat is sent.
REQ-023 FETCH: buf_rd=1, buf_addr per REQ-018 -> LOAD; buf_rd=0 and buf_addr=0 in all other states.
REQ-024 LOAD: register buf_rdata into tdata_m; set tuser_m=(r=0 and f=0) and tlast_m=(r=count-1 and f=2) -> SEND.
REQ-025 SEND: tvalid_m=1; tdata_m, tuser_m and tlast_m hold stable until tvalid_m and tready_m are both high.
REQ-026 SEND handshake on a non-last beat: advance f (after 2: f=0, r+1) -> FETCH.
REQ-027 SEND handshake on the last beat -> DONE.
REQ-028 DONE: done=1 for exactly one cycle -> IDLE; tvalid_m=0.
REQ-029 Latency: start accepted at edge N gives tvalid_m high from cycle N+3. Each beat takes 3 cycles with tready_m held high.
REQ-030 tvalid_m never depends combinationally on tready_m; tvalid_m=0 outside SEND.
REQ-031 start while busy: ignored; count is not re-sampled.
REQ-032 abort in any non-IDLE state: -> IDLE next cycle with tvalid_m=0 and no done pulse. This intentionally breaks the frame; the downstream resyncs on tuser_m.
REQ-033 abort has priority over a simultaneous handshake or start; abort in IDLE has no effect.
REQ-034 ce=0: FSM, counters and outputs frozen. buf_rdata is sampled only in LOAD with ce=1, so ce must stay high from FETCH through LOAD. Handshakes count only when ce=1.
REQ-035 Counters r (8 bit) and f (2 bit) never wrap within a frame; count=255 ends at r=254.

Reset
REQ-036 With reset=1 at a rising edge, state becomes IDLE and r, f and the latched count clear.
REQ-037 Reset values: tvalid_m=0, tuser_m=0, tlast_m=0, tdata_m=0, done=0, busy=0, buf_rd=0, buf_addr=0.
REQ-038 reset overrides ce, start and abort.
REQ-039 Reset mid-frame drops the frame silently with no done pulse.

Verification
REQ-040 count=2, tready_m=1, buffer holds prom {100,-5}, val {300,40}, idx {0x3FF,7} -> 6 beats 100,300,0x03FF,-5,40,7; tuser_m on beat 1, tlast_m on beat 6; done 1 cycle after beat 6.
REQ-041 count=1, tready_m low for 5 cycles during each SEND -> tdata_m stable throughout; 3 beats delivered; first tvalid_m 3 cycles after start.
REQ-042 count=0 with start -> no tvalid_m, no buf_rd; done high exactly at the cycle after start.
REQ-043 count=3, abort during SEND of beat 4 -> tvalid_m low next cycle, busy low, no done; a new start with count=1 then gives a clean frame with tuser_m on its first beat.
REQ-044 start re-pulsed mid-frame with a different count -> ignored; the original 3*count beats are completed.
REQ-045 reset asserted in LOAD with ce=0 -> all outputs at reset values next edge; ce=0 over 4 cycles in SEND -> no state change and tvalid_m held.
